// File: rtl/cdc_xfer_pkg.sv
// Shared types and constants for the source side of the toggle-handshake CDC crossing.
package cdc_xfer_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } xfer_state_e;

    localparam int CNT_W                  = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/cdc_xfer_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo NUM_CH.
module rr_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_idx,
    output logic                      any_valid
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [CH_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!any_valid && req[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Shares one toggle-handshake CDC crossing among NUM_CH requesters, round-robin.
// Optional ack-wait timeout is compiled in with `define CDC_XFER_TIMEOUT_EN.
module cdc_xfer_arbiter
    import cdc_xfer_pkg::*;
#(
    parameter int NUM_CH         = 8,
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         req_valid,
    input  logic [NUM_CH*WIDTH-1:0]   req_data,
    output logic [NUM_CH-1:0]         req_ready,
    output logic [WIDTH-1:0]          xfer_data,
    output logic [$clog2(NUM_CH)-1:0] xfer_ch,
    output logic                      xfer_req_tgl,
    input  logic                      xfer_ack_tgl,
    output logic                      busy,
    output logic [CNT_W-1:0]          xfer_count,
    output logic                      timeout_err
);

    localparam int CH_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("cdc_xfer_arbiter: NUM_CH must be 2..16");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("cdc_xfer_arbiter: TIMEOUT_CYCLES must be 2..65536");
    end

    xfer_state_e      state_q, state_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]  xfer_ch_q, xfer_ch_d;
    logic [WIDTH-1:0] xfer_data_q, xfer_data_d;
    logic             xfer_req_tgl_q, xfer_req_tgl_d;
    logic             ack_meta_q, ack_sync_q;
    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   grant_idx;
    logic              any_valid;
    logic              ack_seen;
    logic              timeout_hit;
    logic [WIDTH-1:0]  words [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_words
        assign words[g] = req_data[g*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Handshake completes when the synchronized ack has caught up with our request toggle.
    assign ack_seen = (ack_sync_q == xfer_req_tgl_q);

`ifdef CDC_XFER_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    // An ack on the expiry edge takes priority over the timeout.
    assign timeout_hit = (state_q == WAIT_ACK) && !ack_seen &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        if (state_q == IDLE) begin
            wait_cnt_d = '0;
        end else if (!ack_seen && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (timeout_hit) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        xfer_ch_d      = xfer_ch_q;
        xfer_data_d    = xfer_data_q;
        xfer_req_tgl_d = xfer_req_tgl_q;
        xfer_count_d   = xfer_count_q;
        req_ready      = '0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    req_ready      = grant;
                    xfer_data_d    = words[grant_idx];
                    xfer_ch_d      = grant_idx;
                    xfer_req_tgl_d = ~xfer_req_tgl_q;
                    rr_ptr_d       = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
                    state_d        = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_seen) begin
                    xfer_count_d = xfer_count_q + 1'b1;
                    state_d      = IDLE;
                end else if (timeout_hit) begin
                    // Abandon the word: re-align so the destination sees no pending request.
                    xfer_req_tgl_d = ack_sync_q;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            xfer_ch_q      <= '0;
            xfer_data_q    <= '0;
            xfer_req_tgl_q <= 1'b0;
            ack_meta_q     <= 1'b0;
            ack_sync_q     <= 1'b0;
            xfer_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            xfer_ch_q      <= xfer_ch_d;
            xfer_data_q    <= xfer_data_d;
            xfer_req_tgl_q <= xfer_req_tgl_d;
            ack_meta_q     <= xfer_ack_tgl;
            ack_sync_q     <= ack_meta_q;
            xfer_count_q   <= xfer_count_d;
        end
    end

    assign xfer_data    = xfer_data_q;
    assign xfer_ch      = xfer_ch_q;
    assign xfer_req_tgl = xfer_req_tgl_q;
    assign busy         = (state_q == WAIT_ACK);
    assign xfer_count   = xfer_count_q;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Bench for cdc_xfer_arbiter: directed grant sequences with a queue-based grant scoreboard
// and a behavioural destination that echoes the request toggle when enabled.
module tb_cdc_xfer_arbiter;

    localparam int NUM_CH = 8;
    localparam int WIDTH  = 32;
    localparam int TO_CYC = 16;
    localparam int CH_W   = 3;
    localparam int W      = CH_W + WIDTH;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b1;
    logic [NUM_CH-1:0]       req_valid = '0;
    logic [NUM_CH*WIDTH-1:0] req_data = '0;
    logic [NUM_CH-1:0]       req_ready;
    logic [WIDTH-1:0]        xfer_data;
    logic [CH_W-1:0]         xfer_ch;
    logic                    xfer_req_tgl;
    logic                    xfer_ack_tgl = 1'b0;
    logic                    busy;
    logic [15:0]             xfer_count;
    logic                    timeout_err;

    int          errors = 0;
    int          checks = 0;
    logic        ack_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [31:0] words [NUM_CH];
    logic [31:0] saved_word;

    always #5 clk = ~clk;

    cdc_xfer_arbiter #(
        .NUM_CH         (NUM_CH),
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .xfer_data    (xfer_data),
        .xfer_ch      (xfer_ch),
        .xfer_req_tgl (xfer_req_tgl),
        .xfer_ack_tgl (xfer_ack_tgl),
        .busy         (busy),
        .xfer_count   (xfer_count),
        .timeout_err  (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_words();
        for (int i = 0; i < NUM_CH; i++) req_data[i*WIDTH +: WIDTH] = words[i];
    endtask

    task automatic push(input int ch);
        exp_q.push_back({CH_W'(ch), words[ch]});
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        ack_en    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the first negedge after the grant edge.
    task automatic wait_ready();
        for (int c = 0; c < 100; c++) begin
            #1;
            if (req_ready != '0) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_ready: no grant within 100 cycles, req_valid=%0h", req_valid);
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!busy) begin
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy still 1 after 100 cycles");
    endtask

    task automatic run_grants(input logic [NUM_CH-1:0] v, input int n);
        req_valid = v;
        ack_en    = 1'b1;
        for (int k = 0; k < n; k++) wait_ready();
        req_valid = '0;
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_xfer_data"}, xfer_data, 0);
        check({tag, "_xfer_ch"}, xfer_ch, 0);
        check({tag, "_xfer_req_tgl"}, xfer_req_tgl, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_xfer_count"}, xfer_count, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // Destination model: mirrors the request toggle back when enabled.
    initial begin : dest_model
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) xfer_ack_tgl = 1'b0;
            else if (ack_en) xfer_ack_tgl = xfer_req_tgl;
        end
    end

    // Scoreboard monitor: each req_ready pulse pops an expected grant; the captured word
    // and channel are checked one cycle later.
    initial begin : monitor
        logic         pending;
        logic [W-1:0] cur;
        pending = 1'b0;
        cur     = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    check("mon_xfer_ch", xfer_ch, cur[W-1:WIDTH]);
                    check("mon_xfer_data", xfer_data, cur[WIDTH-1:0]);
                    check("mon_busy", busy, 1);
                    pending = 1'b0;
                end
                if (req_ready != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mon_unexpected_grant: req_ready=%0h with none expected", req_ready);
                    end else begin
                        cur = exp_q.pop_front();
                        check("mon_req_ready", req_ready, 32'd1 << cur[W-1:WIDTH]);
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        words[0] = 32'h1000_0A0A;
        words[1] = 32'h2111_1B1B;
        words[2] = 32'h3222_2C2C;
        words[3] = 32'h4333_3D3D;
        words[4] = 32'h5444_4E4E;
        words[5] = 32'h6555_5F5F;
        words[6] = 32'h7666_6060;
        words[7] = 32'h8777_7171;
        apply_words();

        // Reset, then a single request with a late ack.
        do_reset();
        #1;
        check_all_zero("reset");
        @(negedge clk);
        push(0);
        req_valid = 8'h01;
        wait_ready();
        req_valid = '0;
        #1;
        check("t1_req_tgl", xfer_req_tgl, 1);
        check("t1_busy", busy, 1);
        repeat (3) @(negedge clk);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t1_busy_2_edges_after_ack", busy, 1);
        @(negedge clk);
        #1;
        check("t1_busy_3_edges_after_ack", busy, 0);
        check("t1_count", xfer_count, 1);
        @(negedge clk);

        // All channels requesting: strict rotation 0..7 then 0.
        do_reset();
        for (int i = 0; i < NUM_CH; i++) push(i);
        push(0);
        run_grants(8'hFF, 9);
        #1;
        check("t2_count", xfer_count, 9);
        @(negedge clk);

        // Move rr_ptr to 5 via a ch4 grant, then ch5 beats ch0.
        do_reset();
        push(4);
        run_grants(8'h10, 1);
        push(5);
        push(0);
        run_grants(8'h21, 2);
        #1;
        check("t3_count", xfer_count, 3);
        @(negedge clk);

        // Requests and data change while waiting for the ack.
        do_reset();
        push(1);
        req_valid = 8'h02;
        wait_ready();
        saved_word = words[1];
        req_valid  = 8'h04;
        words[1]   = 32'hDEAD_BEEF;
        apply_words();
        push(2);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_ready_in_wait", req_ready, 0);
            check("t4_data_held", xfer_data, saved_word);
            check("t4_ch_held", xfer_ch, 1);
            @(negedge clk);
        end
        ack_en = 1'b1;
        wait_ready();
        req_valid = '0;
        wait_idle();
        #1;
        check("t4_count", xfer_count, 2);
        words[1] = saved_word;
        apply_words();
        @(negedge clk);

`ifdef CDC_XFER_TIMEOUT_EN
        // No ack: timeout after 16 WAIT_ACK cycles.
        do_reset();
        push(0);
        req_valid = 8'h01;
        wait_ready();
        req_valid = '0;
        repeat (15) @(negedge clk);
        #1;
        check("t5_busy_before_expiry", busy, 1);
        check("t5_err_before_expiry", timeout_err, 0);
        @(negedge clk);
        #1;
        check("t5_busy_after_expiry", busy, 0);
        check("t5_timeout_err", timeout_err, 1);
        check("t5_req_tgl_realigned", xfer_req_tgl, 0);
        check("t5_count_unchanged", xfer_count, 0);
        @(negedge clk);
        push(3);
        run_grants(8'h08, 1);
        #1;
        check("t5_err_sticky", timeout_err, 1);
        check("t5_count_after_retry", xfer_count, 1);
        @(negedge clk);

        // Ack synchronized exactly on the expiry edge wins.
        do_reset();
        push(0);
        req_valid = 8'h01;
        wait_ready();
        req_valid = '0;
        repeat (13) @(negedge clk);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t6_busy_before_expiry", busy, 1);
        @(negedge clk);
        #1;
        check("t6_busy_after_expiry", busy, 0);
        check("t6_no_error", timeout_err, 0);
        check("t6_count", xfer_count, 1);
        @(negedge clk);
`else
        // Without the timeout the FSM waits indefinitely.
        do_reset();
        push(0);
        req_valid = 8'h01;
        wait_ready();
        req_valid = '0;
        repeat (40) @(negedge clk);
        #1;
        check("t5_still_waiting", busy, 1);
        check("t5_no_error", timeout_err, 0);
        check("t5_count_unchanged", xfer_count, 0);
        @(negedge clk);
        ack_en = 1'b1;
        wait_idle();
        #1;
        check("t5_count_after_ack", xfer_count, 1);
        @(negedge clk);
`endif

        // Counter wrap from 0xFFFF.
        do_reset();
        force dut.xfer_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.xfer_count_q;
        @(negedge clk);
        #1;
        check("t7_count_preload", xfer_count, 16'hFFFF);
        @(negedge clk);
        push(6);
        run_grants(8'h40, 1);
        #1;
        check("t7_count_wrap", xfer_count, 0);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT_ACK.
        push(2);
        req_valid = 8'h04;
        wait_ready();
        req_valid = '0;
        @(negedge clk);
        #3;
        check("t8_busy_before_reset", busy, 1);
        check("t8_data_before_reset", xfer_data, words[2]);
        reset_n = 1'b0;
        #1;
        check_all_zero("t8_midreset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
